// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between fetch and load/store,
// alternating priority on contention and bounding each transfer with a timeout.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_dm_q, last_dm_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                bus_err_q, bus_err_d;

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        wait_cnt_d  = wait_cnt_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            IDLE: if (if_req || dm_req) begin
                // last_dm doubles as the owner of the current transfer
                last_dm_d   = dm_req & ~(if_req & last_dm_q);
                mem_valid_d = 1'b1;
                mem_we_d    = last_dm_d & dm_we;
                mem_be_d    = last_dm_d ? dm_be : '1;
                mem_addr_d  = last_dm_d ? dm_addr : if_addr;
                mem_wdata_d = last_dm_d ? dm_wdata : '0;
                state_d     = XFER;
            end
            XFER: if (mem_ready) begin
                mem_valid_d = 1'b0;
                if_rdata_d  = last_dm_q ? if_rdata_q : mem_rdata;
                dm_rdata_d  = last_dm_q ? mem_rdata : dm_rdata_q;
                state_d     = RESP;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_d == CW'(MAX_WAIT)) begin
                    mem_valid_d = 1'b0;
                    bus_err_d   = 1'b1;
                    if_rdata_d  = last_dm_q ? if_rdata_q : '0;
                    dm_rdata_d  = last_dm_q ? '0 : dm_rdata_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_dm_q   <= 1'b0;
            wait_cnt_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign if_ack    = (state_q == RESP) & ~last_dm_q;
    assign dm_ack    = (state_q == RESP) & last_dm_q;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int MAX_WAIT = 15;

    logic        clk = 0, rst = 0;
    logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic [3:0]  dm_be = 0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, stall_if, stall_mem, mem_valid, mem_we, bus_err;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 60) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: expectations for the current cycle, derived from grant rules and cycle arithmetic
    logic        m_valid = 0, m_ack_if = 0, m_ack_dm = 0, m_own_dm = 0, m_last_dm = 0, m_err = 0;
    logic        m_we = 0;
    logic [3:0]  m_be = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rd = 0, m_dm_rd = 0;
    int          cyc = 0, t_grant = 0;

    task automatic model_step();
        if (!rst) begin
            m_valid = 0; m_ack_if = 0; m_ack_dm = 0; m_own_dm = 0; m_last_dm = 0;
            m_err = 0; m_if_rd = 0; m_dm_rd = 0;
        end else if (m_ack_if || m_ack_dm) begin
            m_ack_if = 0; m_ack_dm = 0;
        end else if (m_valid) begin
            if (mem_ready || cyc - t_grant == MAX_WAIT) begin
                m_valid = 0;
                if (!mem_ready) m_err = 1;
                if (m_own_dm) begin m_ack_dm = 1; m_dm_rd = mem_ready ? mem_rdata : 0; end
                else begin m_ack_if = 1; m_if_rd = mem_ready ? mem_rdata : 0; end
            end
        end else if (if_req || dm_req) begin
            m_own_dm  = dm_req && !(if_req && m_last_dm);
            m_last_dm = m_own_dm;
            m_valid   = 1;
            t_grant   = cyc;
            m_we      = m_own_dm ? dm_we : 1'b0;
            m_be      = m_own_dm ? dm_be : 4'hF;
            m_addr    = m_own_dm ? dm_addr : if_addr;
            m_wdata   = m_own_dm ? dm_wdata : 32'h0;
        end
        cyc++;
    endtask

    initial forever begin
        @(negedge clk);
        chk("mem_valid", mem_valid, m_valid);
        if (m_valid) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_be", mem_be, m_be);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ack", if_ack, m_ack_if);
        chk("dm_ack", dm_ack, m_ack_dm);
        chk("if_rdata", if_rdata, m_if_rd);
        chk("dm_rdata", dm_rdata, m_dm_rd);
        chk("bus_err", bus_err, m_err);
        chk("stall_if", stall_if, if_req & ~m_ack_if);
        chk("stall_mem", stall_mem, dm_req & ~m_ack_dm);
        #2;
        model_step();
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 0; if_req = 0; dm_req = 0; mem_ready = 0;
        #1;
        chk("rst_valid", mem_valid, 0);
        chk("rst_err", bus_err, 0);
        @(negedge clk); #1;
        rst = 1;
    endtask

    task automatic xfer(input bit dm, input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rd,
                        output int vc, output logic [31:0] got, output bit acked, output bit unstable);
        @(negedge clk); #1;
        if (dm) begin dm_req = 1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata; end
        else begin if_req = 1; if_addr = addr; end
        mem_ready = 0; vc = 0; acked = 0; unstable = 0; got = 0;
        for (int i = 0; i < 40 && !acked; i++) begin
            @(negedge clk);
            if (dm ? dm_ack : if_ack) begin acked = 1; got = dm ? dm_rdata : if_rdata; end
            else if (mem_valid) begin
                vc++;
                if (mem_be !== (dm ? be : 4'hF) || mem_addr !== addr) unstable = 1;
            end
            #1;
            mem_ready = !acked && mem_valid && vc > waits;
            mem_rdata = rd;
        end
        if_req = 0; dm_req = 0; mem_ready = 0;
    endtask

    initial begin
        int vc;
        logic [31:0] got;
        bit acked, unstable;
        bit grants[$];
        int dd;
        logic ia, da;
        int mode;
        repeat (3) @(negedge clk);
        #1 rst = 1;

        // single fetch, ready one cycle after mem_valid
        @(negedge clk);
        chk("t1_valid_c0", mem_valid, 0);
        #1 if_req = 1; if_addr = 32'h4;
        #1 chk("t1_stall_c0", stall_if, 1);
        @(negedge clk);
        chk("t1_valid_c1", mem_valid, 1);
        chk("t1_addr_c1", mem_addr, 32'h4);
        chk("t1_be_c1", mem_be, 4'hF);
        chk("t1_we_c1", mem_we, 0);
        chk("t1_stall_c1", stall_if, 1);
        @(negedge clk);
        chk("t1_ack_c2", if_ack, 0);
        chk("t1_stall_c2", stall_if, 1);
        #1 mem_ready = 1; mem_rdata = 32'h0010_0093;
        @(negedge clk);
        chk("t1_ack_c3", if_ack, 1);
        chk("t1_rdata_c3", if_rdata, 32'h0010_0093);
        chk("t1_stall_c3", stall_if, 0);
        #1 if_req = 0; mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        chk("t1_ack_c4", if_ack, 0);

        // simultaneous requests after reset: DM first, then IF
        do_reset();
        @(negedge clk); #1;
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        @(negedge clk);
        chk("t2_valid", mem_valid, 1);
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 32'h100);
        chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        #1 mem_ready = 1;
        @(negedge clk);
        chk("t2_dm_ack", dm_ack, 1);
        chk("t2_if_ack", if_ack, 0);
        chk("t2_stall_if", stall_if, 1);
        #1 dm_req = 0; mem_ready = 0;
        @(negedge clk);
        chk("t2_idle_gap", mem_valid, 0);
        @(negedge clk);
        chk("t2_if_valid", mem_valid, 1);
        chk("t2_if_addr", mem_addr, 32'h40);
        chk("t2_if_we", mem_we, 0);
        #1 mem_ready = 1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("t2_if_ack2", if_ack, 1);
        chk("t2_if_rdata", if_rdata, 32'hCAFE_0001);
        #1 if_req = 0; mem_ready = 0;

        // both held high: grants must alternate
        @(negedge clk); #1;
        if_req = 1; if_addr = 32'h80;
        dm_req = 1; dm_we = 0; dm_addr = 32'h180;
        mem_ready = 1;
        begin
            logic pv = 0;
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                if (mem_valid && !pv) grants.push_back(mem_addr == 32'h180);
                pv = mem_valid;
            end
        end
        chk("t3_grants", grants.size() >= 6, 1);
        if (grants.size() >= 4) begin
            chk("t3_g0_dm", grants[0], 1);
            chk("t3_g1_if", grants[1], 0);
            chk("t3_g2_dm", grants[2], 1);
            chk("t3_g3_if", grants[3], 0);
        end
        dd = 0;
        for (int i = 1; i < grants.size(); i++) if (grants[i] && grants[i-1]) dd++;
        chk("t3_if_skipped_twice", dd, 0);
        #1 if_req = 0; dm_req = 0;
        repeat (4) @(negedge clk);
        #1 mem_ready = 0;

        // timeout
        do_reset();
        xfer(1, 0, 4'hF, 32'h300, 0, 0, 32'h1234_5678, vc, got, acked, unstable);
        chk("t4_pre_rdata", got, 32'h1234_5678);
        chk("t4_pre_err", bus_err, 0);
        xfer(1, 0, 4'hF, 32'h304, 0, 1000, 32'h9999_9999, vc, got, acked, unstable);
        chk("t4_acked", acked, 1);
        chk("t4_valid_cycles", vc, MAX_WAIT);
        chk("t4_rdata_zero", got, 0);
        chk("t4_err", bus_err, 1);
        xfer(0, 0, 4'hF, 32'h20, 0, 0, 32'h55, vc, got, acked, unstable);
        chk("t4_after_rdata", got, 32'h55);
        chk("t4_err_sticky", bus_err, 1);

        // reset during XFER
        @(negedge clk); #1 if_req = 1; if_addr = 32'h10; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_valid) break;
        end
        chk("t5_valid_before", mem_valid, 1);
        #1 rst = 0; if_req = 0;
        #1;
        chk("t5_valid_rst", mem_valid, 0);
        chk("t5_if_ack_rst", if_ack, 0);
        chk("t5_dm_ack_rst", dm_ack, 0);
        chk("t5_err_rst", bus_err, 0);
        @(negedge clk); #1 rst = 1;
        xfer(0, 0, 4'hF, 32'h14, 0, 2, 32'hABCD, vc, got, acked, unstable);
        chk("t5_acked", acked, 1);
        chk("t5_rdata", got, 32'hABCD);
        chk("t5_vc", vc, 3);

        // byte store with wait cycles
        xfer(1, 1, 4'b0010, 32'h204, 32'h0000_AB00, 3, 32'h77, vc, got, acked, unstable);
        chk("t6_acked", acked, 1);
        chk("t6_stable", unstable, 0);
        chk("t6_vc", vc, 4);
        chk("t6_store_rdata", got, 32'h77);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            ia = if_ack; da = dm_ack;
            #1;
            mode = (n / 250) % 4;
            if (n % 1000 == 999) begin
                rst = 0; if_req = 0; dm_req = 0;
            end else begin
                rst = 1;
                if (!if_req || ia) begin
                    if_req = 1'($urandom_range(0, 1));
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end
                if (!dm_req || da) begin
                    dm_req = 1'($urandom_range(0, 1));
                    dm_we = 1'($urandom_range(0, 1));
                    dm_be = 4'($urandom);
                    dm_addr = $urandom;
                    dm_wdata = $urandom;
                end
            end
            mem_ready = mode == 0 ? $urandom_range(0, 1) == 1 :
                        mode == 1 ? $urandom_range(0, 5) == 0 :
                        mode == 3;
            mem_rdata = $urandom;
        end
        #1 rst = 1; if_req = 0; dm_req = 0; mem_ready = 1;
        repeat (6) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
